// File: rtl/key_debounce.sv
// key_debounce: synchronized, debounced push-button with press/release/long-press pulses
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  // The UP/DN cycle that first sees the new level counts as one of the DEBOUNCE_CYCLES,
  // so the debounce state qualifies once its counter has reached DEBOUNCE_CYCLES-2.
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {UP, DEB_DN, DN, DEB_UP} state_t;

  state_t        state_q, state_d;
  logic          sync_q, key_s_q;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // Two-flop synchronizer; idles at 1 (key released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 1'b1;
      key_s_q <= 1'b1;
    end else begin
      sync_q  <= key_n;
      key_s_q <= sync_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UP;
      deb_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // Next state: debounce qualification, hold counting and pulse generation.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      UP: begin
        if (!key_s_q) begin
          state_d = DEB_DN;
          deb_d   = '0;
        end
      end
      DEB_DN: begin
        if (key_s_q) begin
          state_d = UP;
        end else if (deb_q == DEB_LAST) begin
          state_d = DN;
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      DN: begin
        if (key_s_q) begin
          state_d = DEB_UP;
          deb_d   = '0;
        end
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        long_d = (hold_q == HOLD_PRE);
      end
      DEB_UP: begin
        if (!key_s_q) begin
          state_d = DN;
        end else if (deb_q == DEB_LAST) begin
          state_d   = UP;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_d = deb_q + DW'(1);
        end
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        // A release that qualifies first wins; the long press never fires for it.
        long_d = (hold_q == HOLD_PRE) && (state_d != UP);
      end
      default: state_d = UP;
    endcase
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of debounce latency, glitch/bounce rejection, long press and reset
module tb_key_debounce;
  logic clk = 1'b0;
  logic rst_n, key_n;
  logic key_level, key_press, key_release, key_long;
  int checks = 0;
  int errors = 0;
  int cyc, press_cnt, press_at, rel_cnt, rel_at, long_cnt, long_at, lvl_at, overlap, mark;

  key_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; press_cnt = 0; press_at = 0; rel_cnt = 0; rel_at = 0;
    long_cnt = 0; long_at = 0; lvl_at = 0; overlap = 0;
  endtask

  // Advance n rising edges, sampling outputs on each following falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (key_press) begin press_cnt++; press_at = cyc; end
      if (key_release) begin rel_cnt++; rel_at = cyc; end
      if (key_long) begin long_cnt++; long_at = cyc; end
      if (key_level && lvl_at == 0) lvl_at = cyc;
      if (int'(key_press) + int'(key_release) + int'(key_long) > 1) overlap++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    clr();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {key_level, key_press, key_release, key_long}, 0);
    rst_n = 1'b1;
    run(5);
    chk("idle_level", key_level, 0);
    chk("idle_pulses", press_cnt + rel_cnt + long_cnt, 0);

    // Clean press held 30 cycles
    key_n = 1'b0; clr(); run(30);
    chk("clean_press_cnt", press_cnt, 1);
    chk("clean_press_at", press_at, 6);
    chk("clean_level_at", lvl_at, 6);
    chk("clean_long_cnt", long_cnt, 1);
    chk("clean_long_at", long_at, 25);
    chk("clean_level", key_level, 1);
    chk("clean_overlap", overlap, 0);
    key_n = 1'b1; clr(); run(10);
    chk("clean_rel_cnt", rel_cnt, 1);
    chk("clean_rel_at", rel_at, 6);
    chk("clean_rel_level", key_level, 0);
    chk("clean_rel_others", press_cnt + long_cnt, 0);

    // Glitch: 3 low cycles
    key_n = 1'b0; clr(); run(3);
    key_n = 1'b1; run(15);
    chk("glitch_press", press_cnt, 0);
    chk("glitch_level_ever", lvl_at, 0);
    chk("glitch_long", long_cnt, 0);

    // Bounce: low/high pairs, then final fall held
    clr();
    for (int i = 0; i < 3; i++) begin
      key_n = 1'b0; run(2);
      key_n = 1'b1; run(2);
    end
    key_n = 1'b0; mark = cyc; run(12);
    chk("bounce_press_cnt", press_cnt, 1);
    chk("bounce_press_at", press_at, mark + 6);
    chk("bounce_level", key_level, 1);
    key_n = 1'b1; clr(); run(10);
    chk("bounce_rel_cnt", rel_cnt, 1);

    // Short press: 10 low cycles
    key_n = 1'b0; clr(); run(10);
    key_n = 1'b1; mark = cyc; run(14);
    chk("short_press_at", press_at, 6);
    chk("short_rel_cnt", rel_cnt, 1);
    chk("short_rel_at", rel_at, mark + 6);
    chk("short_long", long_cnt, 0);
    chk("short_level", key_level, 0);

    // Release bounce: 2 high cycles while held
    key_n = 1'b0; clr(); run(10);
    key_n = 1'b1; run(2);
    key_n = 1'b0; run(20);
    chk("rbounce_press_cnt", press_cnt, 1);
    chk("rbounce_rel_cnt", rel_cnt, 0);
    chk("rbounce_long_cnt", long_cnt, 1);
    chk("rbounce_long_at", long_at, 25);
    chk("rbounce_level", key_level, 1);
    chk("rbounce_overlap", overlap, 0);

    // Reset mid-press with key held
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {key_level, key_press, key_release, key_long}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_held_outputs", {key_level, key_press, key_release, key_long}, 0);
    rst_n = 1'b1; clr(); run(10);
    chk("rst_repress_cnt", press_cnt, 1);
    chk("rst_repress_at", press_at, 6);
    chk("rst_repress_level", key_level, 1);
    key_n = 1'b1; run(10);
    chk("final_level", key_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
